// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MULDIV_EARLY_OUT_EN skips the iterations for divide-by-zero, signed overflow and zero multiply operands.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic             neg_q;   // negate product / quotient at the end
    logic             neg_r;   // negate remainder (dividend sign)
    logic             div0;
    logic [WIDTH-1:0] a;
  } req_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  req_t               req_q;
  logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q;  // {acc, multiplier} or {remainder, dividend/quotient}

  // Request decode
  logic             a_sgn, b_sgn, b_zero, mul_zero, ovf_in, early_cond, early_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      3'd1, 3'd4, 3'd6: begin a_sgn = src_a[WIDTH-1]; b_sgn = src_b[WIDTH-1]; end
      3'd2:             a_sgn = src_a[WIDTH-1];
      default: ;
    endcase
    mag_a      = a_sgn ? -src_a : src_a;
    mag_b      = b_sgn ? -src_b : src_b;
    b_zero     = (src_b == '0);
    mul_zero   = (src_a == '0) || b_zero;
    ovf_in     = !op[0] && (src_a == MIN_NEG) && (src_b == '1);
    early_cond = op[2] ? (b_zero || ovf_in) : mul_zero;
`ifdef MULDIV_EARLY_OUT_EN
    early_in   = early_cond;
`else
    early_in   = 1'b0;
`endif
  end

  // One iteration step for each datapath
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up and special cases
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_res;

  always_comb begin
    prod_s = req_q.neg_q ? -prod_q : prod_q;
    quo_s  = req_q.neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_s  = req_q.neg_r ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    case (req_q.op)
      3'd0:             fin_res = prod_s[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fin_res = prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       fin_res = req_q.div0 ? '1 : quo_s;
      default:          fin_res = req_q.div0 ? req_q.a : rem_s;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req_q  <= '{op: op, neg_q: a_sgn ^ b_sgn, neg_r: a_sgn, div0: b_zero, a: src_a};
          opnd_q <= op[2] ? mag_b : mag_a;
          // A zero multiplier register already yields a zero product, with or without iterations
          if (!op[2] && early_cond) prod_q <= '0;
          else                      prod_q <= {{WIDTH{1'b0}}, op[2] ? mag_a : mag_b};
          cnt    <= early_in ? '0 : CW'(WIDTH);
          state  <= BUSY;
        end
        BUSY: if (cnt != '0) begin
          prod_q <= req_q.op[2] ? div_next : mul_next;
          cnt    <= cnt - CW'(1);
        end else begin
          state     <= DONE;
          out_valid <= 1'b1;
          result    <= fin_res;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          result    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: driver pushes model results, a negedge monitor pops and compares.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, kill, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b, result;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: plain 64-bit arithmetic on the RV32M definitions
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(ua * ub);  return p[31:0];  end
      3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
      3'd3: begin p = 64'(ua * ub);  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = 64'(sa / sbv); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sbv); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit early;
    int lat = 33;
    if (o[2]) early = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      early = (a == 0) || (b == 0);
    if (early) begin
`ifdef MULDIV_EARLY_OUT_EN
      lat = 1;
`endif
    end
    return lat;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
    int n = 0;
    int lat = ref_lat(o, a, b);
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin fail_evt("in_ready_timeout"); return; end
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    if (track) sb.push_back('{ref_res(o, a, b), lat, cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    if (lat == 33) begin
      // Requests presented while busy must be ignored
      in_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; op = 3'($urandom); src_a = $urandom; end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin fail_evt("drain_timeout"); sb.delete(); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Consumer side: random backpressure unless a test pins it
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    bit have_first = 0, hold = 0, exp_idle = 0;
    logic [31:0] hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_idle) begin chk("ready_after_take", 32'(in_ready), 32'd1); exp_idle = 0; end
        if (out_valid) begin
          chk("no_reaccept_in_done", 32'(in_ready), 32'd0);
          if (!have_first) begin
            have_first = 1;
            if (sb.size() == 0) fail_evt("unexpected_out_valid");
            else chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          end
          if (hold) chk("hold_stable", result, hold_val);
          if (out_ready) begin
            if (sb.size() != 0) begin chk("result", result, sb[0].res); void'(sb.pop_front()); end
            have_first = 0; hold = 0; exp_idle = 1;
          end else begin
            hold = 1; hold_val = result;
          end
        end else begin
          if (hold) begin fail_evt("out_valid_dropped"); hold = 0; end
          chk("result_zero_when_invalid", result, 32'h0);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);
    drain();

    // Backpressure: hold DONE for 10 cycles
    rdy_mode = 1;
    issue(3'd0, 32'd123, 32'd456, 1'b1);
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail_evt("out_valid_timeout");
    repeat (10) begin @(posedge clk); #1; end
    rdy_mode = 2;
    drain();
    rdy_mode = 0;

    // Kill at iteration 5
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_in_ready", 32'(in_ready), 32'd1);
    chk("kill_out_valid", 32'(out_valid), 32'd0);
    repeat (40) begin @(posedge clk); #1; end

    // Kill coincident with accept drops the request
    op = 3'd5; src_a = 32'd9; src_b = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_accept_in_ready", 32'(in_ready), 32'd1);
    repeat (40) begin @(posedge clk); #1; end

    // Reset at iteration 20
    issue(3'd4, 32'd1000, 32'd7, 1'b0);
    repeat (18) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy_out_valid", 32'(out_valid), 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    issue(3'd0, 32'd3, 32'd4, 1'b1);
    drain();

    for (int i = 0; i < 80; i++) issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  unit able to accept a request.
REQ-006 SHALL have port op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port src_a  input  WIDTH  rs1 operand (multiplicand/dividend).
REQ-008 SHALL have port src_b  input  WIDTH  rs2 operand (multiplier/divisor).
REQ-009 SHALL have port kill  input  1  abort current operation, discard result.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer (writeback mux) takes result.
REQ-012 SHALL have port result  output  WIDTH  result, feeds register-file writeback alongside adder/shifter outputs.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready, latching op, src_a, src_b.
REQ-015 SHALL, on accept, enter BUSY with iteration counter = WIDTH; one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes).
REQ-016 SHALL leave BUSY for DONE when counter reaches 0; out_valid first high exactly WIDTH+1 cycles after the accept cycle (33 for WIDTH=32).
REQ-017 SHALL hold out_valid and result stable in DONE until out_ready is high; then go to IDLE, in_ready high the following cycle (no same-cycle re-accept).
REQ-018 SHALL return low WIDTH bits of product for MUL; high WIDTH bits for MULH (s*s), MULHSU (signed src_a * unsigned src_b), MULHU (u*u).
REQ-019 SHALL for DIV/REM compute on magnitudes, negate quotient when operand signs differ, give remainder the dividend's sign (truncation toward zero).
REQ-020 SHALL for divisor 0 return quotient all-ones and remainder = src_a (signed and unsigned).
REQ-021 SHALL for DIV/REM with src_a = -2^(WIDTH-1), src_b = -1 return quotient -2^(WIDTH-1), remainder 0.
REQ-022 SHALL, when kill is high in any state, go to IDLE next cycle with out_valid low; kill wins over simultaneous out_valid && out_ready and over simultaneous accept (request dropped).
REQ-023 SHALL ignore in_valid, op, src_a, src_b while BUSY or DONE.
REQ-024 SHALL drive result = 0 whenever out_valid is low.

Reset
REQ-025 SHALL on rst: state IDLE, counter 0, out_valid 0, result 0, in_ready 1 in the cycle after rst deasserts.
REQ-026 SHALL abandon an in-flight operation on rst mid-BUSY or mid-DONE with no result emitted; rst has priority over kill and all handshakes.

Configuration
REQ-027 SHALL, with macro MULDIV_EARLY_OUT_EN defined, go directly to DONE for divisor 0, signed overflow (REQ-021), or any multiply operand 0, so out_valid is high the cycle after accept.
REQ-028 SHALL, without MULDIV_EARLY_OUT_EN, run all WIDTH iterations for every op; results identical to the macro-defined build.

Verification
REQ-029 SHALL cover: MUL src_a=7, src_b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-030 SHALL cover: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-032 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; latency 1 with MULDIV_EARLY_OUT_EN, 33 without.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid and result stable; release -> in_ready high next cycle.
REQ-034 SHALL cover: kill at iteration 5, and rst at iteration 20 -> IDLE next cycle, no out_valid pulse, subsequent MUL 3*4 -> 12.
